bus_hub_n: RTL and testbench
============================

Name: bus_hub_n

Overview:
Parametrised N-device successor to the fixed two-device bus hub. Sits between the CPU core's bus master port and the memory and peripheral slaves. Decodes addresses internally from per-device base/mask windows, so slaves no longer self-decode, and presents base-relative offsets to each slave. Adds a per-transaction timeout, an error response for unmapped or hung accesses, and error logging registers.

Parameters:
N_DEV, 4, number of device ports (1..16)
ADDR_W, 32, address width
DATA_W, 32, data width; write mask is DATA_W/8 bits
DEV_BASE, {N_DEV{32'h0}}, packed N_DEV*ADDR_W base addresses; device i occupies slice i
DEV_MASK, {N_DEV{32'hFFFFF000}}, packed N_DEV*ADDR_W match masks; hit when (addr & mask) == (base & mask)
TIMEOUT, 255, device-wait cycles before error response; 0 disables timeout
ERR_DATA, 32'hDEADBEEF, read data returned on an error response

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
host_address  in  ADDR_W  request address, held stable until host_ready
host_data_write  in  DATA_W  write data
host_write_mask  in  DATA_W/8  byte enables
host_wen  in  1  write request (level)
host_ren  in  1  read request (level)
host_data_read  out  DATA_W  registered read data, valid with host_ready
host_ready  out  1  one-cycle completion pulse
host_error  out  1  one-cycle pulse coincident with host_ready on an error completion
device_address  out  N_DEV*ADDR_W  per-device offset = addr & ~DEV_MASK[i]
device_data_write  out  N_DEV*DATA_W  write data, broadcast
device_write_mask  out  N_DEV*DATA_W/8  byte enables, broadcast
device_ren  out  N_DEV  read strobe, held until that device's ready
device_wen  out  N_DEV  write strobe, held until that device's ready
device_ready  in  N_DEV  device completion
device_data_read  in  N_DEV*DATA_W  device read data, valid with device_ready
err_count  out  16  saturating count of error completions
err_addr  out  ADDR_W  address of most recent error

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs go to 0, including every device strobe, host_ready, host_error, err_count and err_addr.
  - Strobes drop immediately, even mid-transaction.
  - No completion is issued for an aborted transaction.
- States: IDLE, ACCESS, RESPOND.
- IDLE, on (host_ren | host_wen):
  - Latch address, wdata, mask and op. wen has priority when both are high; the op is a write.
  - Decode: the lowest-index hitting device wins on overlap.
  - Hit: select device, go to ACCESS.
  - No hit: go to RESPOND with error.
- ACCESS:
  - Assert device_ren[sel] or device_wen[sel]; all other strobes stay 0.
  - The timeout counter increments each cycle.
  - On device_ready[sel]: capture device_data_read[sel] (reads) and go to RESPOND. This takes priority over a timeout in the same cycle.
  - When the counter reaches TIMEOUT (TIMEOUT != 0) without ready: drop the strobe and go to RESPOND with error.
  - device_ready from unselected devices is ignored.
- RESPOND:
  - Pulse host_ready for one cycle, with host_data_read = captured data, ERR_DATA on a read error, or 0 on writes.
  - On error: pulse host_error, set err_addr to the latched address, increment err_count (saturates at 16'hFFFF).
  - Return to IDLE.
- Minimum latency: request in IDLE at cycle 0, strobe at cycle 1, device ready at cycle 1 gives host_ready at cycle 2. An unmapped access gives host_ready at cycle 1.
- Back-to-back: a host holding a strobe high after ready is re-sampled in IDLE as a new request. The host must update or drop its strobe in the cycle following host_ready.
- Device data and ready are never combinationally forwarded to the host; all host outputs are registered.

Decomposition:
- Package soc_bus_pkg:
  - hub_state_t enum {IDLE, ACCESS, RESPOND}
  - BUS_ADDR_W / BUS_DATA_W constants
  - default ERR_DATA constant
  - bus_req_t struct {addr, wdata, wmask, wen}
- Sub-module bus_addr_decoder (combinational): DEV_BASE/DEV_MASK plus address produce a one-hot hit vector, a priority-encoded index and a valid bit. It is reused by future bridges.

Test Plan:
- Read 0x0000_2004, DEV_BASE[1]=0x2000, mask 0xFFFFF000, device 1 ready after 3 cycles with 0x12345678 -> device_address[1]=0x004, only device_ren[1] high for 3 cycles, host_ready one cycle later with 0x12345678, host_error=0.
- Write 0xAABBCCDD mask 4'b0101 to device 0 with same-cycle ready -> device_wen[0] for 1 cycle, data and mask broadcast unchanged, host_ready at cycle 2.
- Read 0xF000_0000 (unmapped) -> no device strobe, host_ready+host_error at cycle 1, data 0xDEADBEEF, err_count=1, err_addr=0xF000_0000.
- TIMEOUT=8, device never ready -> strobe high 8 cycles then low, error completion. A second timeout gives err_count=2.
- Overlapping windows dev0/dev2 both hit, ren and wen both high -> only device_wen[0] asserted.
- rst_n low mid-ACCESS -> all strobes 0 asynchronously, no host_ready, err_count=0 after release; the next request completes normally.

Source files
------------

// File: rtl/soc_bus_pkg.sv
// Shared bus types and constants for the SoC hub and bridge blocks.
package soc_bus_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam logic [BUS_DATA_W-1:0] DEF_ERR_DATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } hub_state_t;

  typedef struct packed {
    logic [BUS_ADDR_W-1:0]   addr;
    logic [BUS_DATA_W-1:0]   wdata;
    logic [BUS_DATA_W/8-1:0] wmask;
    logic                    wen;
  } bus_req_t;

endpackage

// File: rtl/bus_addr_decoder.sv
// Window decoder: per-device base/mask match, lowest index wins on overlap.
module bus_addr_decoder
  import soc_bus_pkg::*;
#(
  parameter int                        N_DEV    = 4,
  parameter int                        ADDR_W   = BUS_ADDR_W,
  parameter logic [N_DEV*ADDR_W-1:0]   DEV_BASE = '0,
  parameter logic [N_DEV*ADDR_W-1:0]   DEV_MASK = '0,
  parameter int                        IDX_W    = (N_DEV > 1) ? $clog2(N_DEV) : 1
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [N_DEV-1:0]  hit,
  output logic [IDX_W-1:0]  idx,
  output logic              valid
);

  always_comb begin
    hit   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < N_DEV; i++) begin
      hit[i] = ((addr & DEV_MASK[i*ADDR_W +: ADDR_W]) ==
                (DEV_BASE[i*ADDR_W +: ADDR_W] & DEV_MASK[i*ADDR_W +: ADDR_W]));
    end
    for (int unsigned i = 0; i < N_DEV; i++) begin
      if (hit[i] && !valid) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_hub_n.sv
// N-device bus hub: address decode, per-access timeout, error response and logging.
module bus_hub_n
  import soc_bus_pkg::*;
#(
  parameter int                            N_DEV    = 4,
  parameter int                            ADDR_W   = BUS_ADDR_W,
  parameter int                            DATA_W   = BUS_DATA_W,
  parameter logic [N_DEV*ADDR_W-1:0]       DEV_BASE = {N_DEV{32'h0}},
  parameter logic [N_DEV*ADDR_W-1:0]       DEV_MASK = {N_DEV{32'hFFFFF000}},
  parameter int                            TIMEOUT  = 255,
  parameter logic [DATA_W-1:0]             ERR_DATA = DATA_W'(DEF_ERR_DATA)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [ADDR_W-1:0]           host_address,
  input  logic [DATA_W-1:0]           host_data_write,
  input  logic [DATA_W/8-1:0]         host_write_mask,
  input  logic                        host_wen,
  input  logic                        host_ren,
  output logic [DATA_W-1:0]           host_data_read,
  output logic                        host_ready,
  output logic                        host_error,
  output logic [N_DEV*ADDR_W-1:0]     device_address,
  output logic [N_DEV*DATA_W-1:0]     device_data_write,
  output logic [N_DEV*DATA_W/8-1:0]   device_write_mask,
  output logic [N_DEV-1:0]            device_ren,
  output logic [N_DEV-1:0]            device_wen,
  input  logic [N_DEV-1:0]            device_ready,
  input  logic [N_DEV*DATA_W-1:0]     device_data_read,
  output logic [15:0]                 err_count,
  output logic [ADDR_W-1:0]           err_addr
);

  localparam int IDX_W  = (N_DEV > 1) ? $clog2(N_DEV) : 1;
  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_ACCESS  = ACCESS;
  localparam logic [1:0] ST_RESPOND = RESPOND;

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] wmask_q;
  logic              wr_q;
  logic [IDX_W-1:0]  sel_q;
  logic [CNT_W-1:0]  cnt;

  logic [N_DEV-1:0]  dec_hit;
  logic [IDX_W-1:0]  dec_idx;
  logic              dec_valid;
  logic              sel_ready;
  logic [DATA_W-1:0] sel_rdata;
  logic              timeout_hit;

  bus_addr_decoder #(
    .N_DEV    (N_DEV),
    .ADDR_W   (ADDR_W),
    .DEV_BASE (DEV_BASE),
    .DEV_MASK (DEV_MASK),
    .IDX_W    (IDX_W)
  ) u_dec (
    .addr  (host_address),
    .hit   (dec_hit),
    .idx   (dec_idx),
    .valid (dec_valid)
  );

  // Only the selected device's ready/data are ever looked at.
  always_comb begin
    sel_ready  = 1'b0;
    sel_rdata  = '0;
    device_ren = '0;
    device_wen = '0;
    for (int unsigned i = 0; i < N_DEV; i++) begin
      if (sel_q == IDX_W'(i)) begin
        sel_ready = device_ready[i];
        sel_rdata = device_data_read[i*DATA_W +: DATA_W];
        if (state == ST_ACCESS) begin
          device_ren[i] = !wr_q;
          device_wen[i] = wr_q;
        end
      end
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

  for (genvar g = 0; g < N_DEV; g++) begin : g_dev
    assign device_address[g*ADDR_W +: ADDR_W] = addr_q & ~DEV_MASK[g*ADDR_W +: ADDR_W];
  end
  assign device_data_write = {N_DEV{wdata_q}};
  assign device_write_mask = {N_DEV{wmask_q}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      addr_q         <= '0;
      wdata_q        <= '0;
      wmask_q        <= '0;
      wr_q           <= 1'b0;
      sel_q          <= '0;
      cnt            <= '0;
      host_ready     <= 1'b0;
      host_error     <= 1'b0;
      host_data_read <= '0;
      err_count      <= '0;
      err_addr       <= '0;
    end else begin
      host_ready     <= 1'b0;
      host_error     <= 1'b0;
      host_data_read <= '0;
      case (state)
        ST_IDLE: begin
          if (host_ren || host_wen) begin
            addr_q  <= host_address;
            wdata_q <= host_data_write;
            wmask_q <= host_write_mask;
            wr_q    <= host_wen;
            sel_q   <= dec_idx;
            cnt     <= '0;
            if (dec_valid) begin
              state <= ST_ACCESS;
            end else begin
              state          <= ST_RESPOND;
              host_ready     <= 1'b1;
              host_error     <= 1'b1;
              host_data_read <= host_wen ? '0 : ERR_DATA;
            end
          end
        end
        ST_ACCESS: begin
          if (sel_ready) begin
            state          <= ST_RESPOND;
            host_ready     <= 1'b1;
            host_data_read <= wr_q ? '0 : sel_rdata;
          end else if (timeout_hit) begin
            state          <= ST_RESPOND;
            host_ready     <= 1'b1;
            host_error     <= 1'b1;
            host_data_read <= wr_q ? '0 : ERR_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESPOND: begin
          state <= ST_IDLE;
          if (host_error) begin
            err_addr <= addr_q;
            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_hub_n.sv
// Bench for bus_hub_n: directed vector table, reset-abort sequence and randomized traffic.
module tb_bus_hub_n;

  localparam int TO = 8;

  logic         clk;
  logic         rst_n;
  logic [31:0]  host_address;
  logic [31:0]  host_data_write;
  logic [3:0]   host_write_mask;
  logic         host_wen;
  logic         host_ren;
  logic [31:0]  host_data_read;
  logic         host_ready;
  logic         host_error;
  logic [127:0] device_address;
  logic [127:0] device_data_write;
  logic [15:0]  device_write_mask;
  logic [3:0]   device_ren;
  logic [3:0]   device_wen;
  logic [3:0]   device_ready;
  logic [127:0] device_data_read;
  logic [15:0]  err_count;
  logic [31:0]  err_addr;

  logic [31:0] base_a [4] = '{32'h0000_0000, 32'h0000_2000, 32'h0000_0000, 32'h8000_0000};
  logic [31:0] mask_a [4] = '{32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_0000, 32'hF000_0000};

  bus_hub_n #(
    .N_DEV    (4),
    .ADDR_W   (32),
    .DATA_W   (32),
    .DEV_BASE ({32'h8000_0000, 32'h0000_0000, 32'h0000_2000, 32'h0000_0000}),
    .DEV_MASK ({32'hF000_0000, 32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_F000}),
    .TIMEOUT  (TO),
    .ERR_DATA (32'hDEADBEEF)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .host_address      (host_address),
    .host_data_write   (host_data_write),
    .host_write_mask   (host_write_mask),
    .host_wen          (host_wen),
    .host_ren          (host_ren),
    .host_data_read    (host_data_read),
    .host_ready        (host_ready),
    .host_error        (host_error),
    .device_address    (device_address),
    .device_data_write (device_data_write),
    .device_write_mask (device_write_mask),
    .device_ren        (device_ren),
    .device_wen        (device_wen),
    .device_ready      (device_ready),
    .device_data_read  (device_data_read),
    .err_count         (err_count),
    .err_addr          (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        wen;
    logic        ren;
    int          lat;       // strobe cycle in which device asserts ready; 0 = never
    logic [31:0] rdata;
    int          exp_dev;   // -1 = unmapped
    logic        exp_wr;
    logic        exp_err;
    logic [31:0] exp_off;
    logic [31:0] exp_data;
    int          exp_lat;   // cycle of host_ready after request
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          exp_cnt = 0;
  logic [31:0] exp_eaddr = '0;
  vec_t        tbl [8];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int model_dev(input logic [31:0] a);
    for (int i = 0; i < 4; i++)
      if ((a & mask_a[i]) == (base_a[i] & mask_a[i])) return i;
    return -1;
  endfunction

  function automatic vec_t model_vec(input logic [31:0] a, input logic [31:0] wd,
                                     input logic [3:0] wm, input logic w, input logic r,
                                     input int lat, input logic [31:0] rd);
    vec_t v;
    v.addr = a; v.wdata = wd; v.wmask = wm; v.wen = w; v.ren = r; v.lat = lat; v.rdata = rd;
    v.exp_dev = model_dev(a);
    v.exp_wr  = w;
    v.exp_err = (v.exp_dev < 0) || (lat == 0);
    v.exp_off = (v.exp_dev >= 0) ? (a & ~mask_a[v.exp_dev]) : 32'h0;
    if (w)              v.exp_data = 32'h0;
    else if (v.exp_err) v.exp_data = 32'hDEADBEEF;
    else                v.exp_data = rd;
    if (v.exp_dev < 0)  v.exp_lat = 1;
    else if (lat == 0)  v.exp_lat = TO + 1;
    else                v.exp_lat = lat + 1;
    return v;
  endfunction

  task automatic run_txn(input vec_t v);
    int          strobes = 0;
    bit          done = 0;
    logic [3:0]  selbit;
    logic [3:0]  nz;
    selbit = (v.exp_dev >= 0) ? (4'b0001 << v.exp_dev) : 4'b0000;
    @(negedge clk);
    host_address    = v.addr;
    host_data_write = v.wdata;
    host_write_mask = v.wmask;
    host_wen        = v.wen;
    host_ren        = v.ren;
    device_ready    = '0;
    for (int c = 1; c <= 60 && !done; c++) begin
      @(negedge clk);
      if (host_ready) begin
        done = 1;
        chk("latency", 128'(c), 128'(v.exp_lat));
        chk("rdata", host_data_read, v.exp_data);
        chk("error", host_error, v.exp_err);
        chk("strobes_off", {device_ren, device_wen}, 8'h00);
        host_ren     = 1'b0;
        host_wen     = 1'b0;
        device_ready = '0;
      end else if ((device_ren | device_wen) != 4'b0000) begin
        strobes++;
        chk("dev_ren", device_ren, v.exp_wr ? 4'b0000 : selbit);
        chk("dev_wen", device_wen, v.exp_wr ? selbit : 4'b0000);
        if (strobes == 1 && v.exp_dev >= 0) begin
          chk("offset", device_address[v.exp_dev*32 +: 32], v.exp_off);
          chk("wdata_bcast", device_data_write, {4{v.wdata}});
          chk("wmask_bcast", device_write_mask, {4{v.wmask}});
        end
        nz = 4'($urandom);
        device_ready     = nz & ~selbit;
        device_data_read = {$urandom, $urandom, $urandom, $urandom};
        if (v.exp_dev >= 0) device_data_read[v.exp_dev*32 +: 32] = v.rdata;
        if (v.lat != 0 && strobes == v.lat) device_ready = device_ready | selbit;
      end else begin
        device_ready = '0;
      end
    end
    if (!done) begin
      chk("host_ready_wait", 128'(0), 128'(1));
      host_ren = 1'b0;
      host_wen = 1'b0;
      device_ready = '0;
    end
    chk("strobe_cycles", 128'(strobes), 128'(v.exp_lat - 1));
    if (v.exp_err) begin
      exp_cnt++;
      exp_eaddr = v.addr;
    end
    @(negedge clk);
    chk("ready_pulse", host_ready, 1'b0);
    chk("err_count", err_count, 16'(exp_cnt));
    chk("err_addr", err_addr, exp_eaddr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{32'h0000_2004, 32'h0, 4'h0, 1'b0, 1'b1, 3, 32'h1234_5678, 1, 1'b0, 1'b0, 32'h004, 32'h1234_5678, 4};
    tbl[1] = '{32'h0000_0010, 32'hAABB_CCDD, 4'b0101, 1'b1, 1'b0, 1, 32'h0, 0, 1'b1, 1'b0, 32'h010, 32'h0, 2};
    tbl[2] = '{32'hF000_0000, 32'h0, 4'h0, 1'b0, 1'b1, 1, 32'h0, -1, 1'b0, 1'b1, 32'h0, 32'hDEAD_BEEF, 1};
    tbl[3] = '{32'h8000_0100, 32'h0, 4'h0, 1'b0, 1'b1, 0, 32'h0, 3, 1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, TO + 1};
    tbl[4] = '{32'h0000_2008, 32'h1122_3344, 4'hF, 1'b1, 1'b0, 0, 32'h0, 1, 1'b1, 1'b1, 32'h008, 32'h0, TO + 1};
    tbl[5] = '{32'h0000_0C00, 32'h5566_7788, 4'b1100, 1'b1, 1'b1, 2, 32'h9999_9999, 0, 1'b1, 1'b0, 32'hC00, 32'h0, 3};
    tbl[6] = '{32'h0000_5000, 32'h0, 4'h0, 1'b0, 1'b1, 1, 32'h0BAD_F00D, 2, 1'b0, 1'b0, 32'h5000, 32'h0BAD_F00D, 2};
    tbl[7] = '{32'h8ABC_DEF0, 32'h0, 4'h0, 1'b0, 1'b1, 2, 32'hCAFE_F00D, 3, 1'b0, 1'b0, 32'h0ABC_DEF0, 32'hCAFE_F00D, 3};

    rst_n = 1'b0;
    host_address = '0; host_data_write = '0; host_write_mask = '0;
    host_wen = 1'b0; host_ren = 1'b0;
    device_ready = '0; device_data_read = '0;
    #1;
    chk("rst_ready", host_ready, 1'b0);
    chk("rst_error", host_error, 1'b0);
    chk("rst_rdata", host_data_read, 32'h0);
    chk("rst_strobes", {device_ren, device_wen}, 8'h00);
    chk("rst_devaddr", device_address, 128'h0);
    chk("rst_errcnt", err_count, 16'h0);
    chk("rst_erraddr", err_addr, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_txn(tbl[i]);

    // Abort a hung read mid-access with an asynchronous reset.
    @(negedge clk);
    host_address = 32'h0000_2000;
    host_ren     = 1'b1;
    device_ready = '0;
    repeat (3) @(negedge clk);
    chk("abort_pre_ren", device_ren, 4'b0010);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ren", device_ren, 4'b0000);
    chk("abort_wen", device_wen, 4'b0000);
    chk("abort_ready", host_ready, 1'b0);
    chk("abort_errcnt", err_count, 16'h0);
    chk("abort_erraddr", err_addr, 32'h0);
    host_ren = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_cnt   = 0;
    exp_eaddr = '0;
    repeat (2) @(negedge clk);
    chk("abort_no_cmpl", host_ready, 1'b0);
    run_txn(tbl[0]);

    for (int k = 0; k < 40; k++) begin
      int          r;
      int          lat;
      int          op;
      logic [31:0] a;
      r = $urandom_range(0, 4);
      if (r < 4) a = base_a[r] | ($urandom & ~mask_a[r]);
      else       a = $urandom;
      op  = $urandom_range(1, 3);
      lat = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4);
      run_txn(model_vec(a, $urandom, 4'($urandom), op[0], op[1], lat, $urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
